button_event_arbiter: RTL

Collects rising-edge events from N slowly sampled push-button inputs and serialises them, one at a time, to a single shared downstream consumer through a valid/ready handshake with round-robin fairness. It sits between the raw board buttons and any shared resource, such as a counter, display or FSM, that can accept only one command at a time. Each button keeps one pending event. Extra presses that arrive while an event is still pending are dropped and counted.

---
 rtl/button_event_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: samples N push buttons, keeps one pending event per
// button and serialises them round-robin over a valid/ready handshake.
module button_event_arbiter #(
    parameter int N   = 4,
    parameter int DIV = 100000,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   btn,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    input  logic           evt_ready,
    output logic [N-1:0]   pending,
    output logic [7:0]     miss_cnt
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
    localparam logic [IDW-1:0] ID_MAX  = IDW'(N - 1);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sync1_q, sync2_q;
    logic [N-1:0]   prev_q, prev_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [7:0]     miss_q, miss_d;
    logic [8:0]     miss_sum;
    logic [N-1:0]   rise, acc_vec, miss;
    logic [IDW-1:0] pick;
    logic           strobe, accept;

    function automatic logic [4:0] popcount(input logic [N-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {4'b0, v[i]};
        end
        return c;
    endfunction

    // Highest k is visited first, so the lowest offset from ptr wins.
    function automatic logic [IDW-1:0] rr_pick(
        input logic [N-1:0]   req,
        input logic [IDW-1:0] ptr
    );
        logic [IDW-1:0] sel;
        logic [IDW-1:0] jj;
        int             j;
        sel = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IDW'(j);
            if (req[jj]) begin
                sel = jj;
            end
        end
        return sel;
    endfunction

    assign strobe   = (cnt_q == CNT_MAX);
    assign cnt_d    = strobe ? '0 : cnt_q + 1'b1;
    assign prev_d   = strobe ? sync2_q : prev_q;
    assign rise     = {N{strobe}} & sync2_q & ~prev_q;
    assign accept   = (state_q == OFFER) && evt_ready;
    assign acc_vec  = accept ? (N'(1) << id_q) : '0;
    assign pend_d   = (pend_q & ~acc_vec) | rise;
    assign miss     = rise & pend_q & ~acc_vec;
    assign miss_sum = {1'b0, miss_q} + {4'b0, popcount(miss)};
    assign miss_d   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    assign pick     = rr_pick(pend_q, rr_q);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    id_d    = pick;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    state_d = IDLE;
                    rr_d    = (id_q == ID_MAX) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            miss_q  <= '0;
            state_q <= IDLE;
            id_q    <= '0;
            rr_q    <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            miss_q  <= miss_d;
            state_q <= state_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
        end
    end

    assign evt_valid = (state_q == OFFER);
    assign evt_id    = id_q;
    assign pending   = pend_q;
    assign miss_cnt  = miss_q;

endmodule
